// File: rtl/alu_writeback_if.sv
// Instruction, register-write, branch and data-memory signals of the writeback stage.
interface alu_writeback_if;
  // instruction handshake and payload
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [1:0] func;
  logic [7:0] alu_out;
  logic       zero;
  logic [7:0] store_data;
  logic [2:0] wr_reg;
  logic [7:0] branch_target;
  // register-file write port
  logic       reg_wr_en;
  logic [2:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  // branch redirect
  logic       branch_taken;
  logic [7:0] branch_addr;
  // data memory
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       mem_err;

  // upstream/memory side: presents instructions and memory responses
  modport master (
    output in_valid, op, func, alu_out, zero, store_data, wr_reg, branch_target,
    output mem_ack, mem_rdata,
    input  in_ready, reg_wr_en, reg_wr_addr, reg_wr_data, branch_taken, branch_addr,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_err
  );

  // writeback stage side
  modport slave (
    input  in_valid, op, func, alu_out, zero, store_data, wr_reg, branch_target,
    input  mem_ack, mem_rdata,
    output in_ready, reg_wr_en, reg_wr_addr, reg_wr_data, branch_taken, branch_addr,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_err
  );
endinterface

// File: rtl/alu_writeback.sv
// Writeback stage: retires ALU results, resolves BEQ, and runs LW/SW memory
// transactions with a bounded wait for the memory acknowledge.
module alu_writeback #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic            clk,
  input logic            reset,
  alu_writeback_if.slave bus
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, MEM_WAIT, WB} state_t;
  typedef enum logic [2:0] {K_NOP, K_ALU, K_BEQ, K_SW, K_LW} kind_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         wb_addr_q, wb_addr_d;
  logic               reg_wr_en_q, reg_wr_en_d;
  logic [2:0]         reg_wr_addr_q, reg_wr_addr_d;
  logic [7:0]         reg_wr_data_q, reg_wr_data_d;
  logic               branch_taken_q, branch_taken_d;
  logic [7:0]         branch_addr_q, branch_addr_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [7:0]         mem_addr_q, mem_addr_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;
  logic               mem_err_q, mem_err_d;
  kind_t              kind;
  logic               timeout_hit;

  // Instruction class from op/function
  always_comb begin
    kind = K_NOP;
    case (bus.op)
      2'b00:   kind = bus.func[0] ? K_BEQ : K_ALU;
      2'b01: begin
        case (bus.func)
          2'b00:   kind = K_SW;
          2'b01:   kind = K_LW;
          default: kind = K_ALU;
        endcase
      end
      default: kind = bus.func[1] ? K_NOP : K_ALU;
    endcase
  end

  assign timeout_hit = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // Next state and next registered outputs
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wb_addr_d      = wb_addr_q;
    reg_wr_en_d    = 1'b0;
    reg_wr_addr_d  = reg_wr_addr_q;
    reg_wr_data_d  = reg_wr_data_q;
    branch_taken_d = 1'b0;
    branch_addr_d  = branch_addr_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          case (kind)
            K_ALU: begin
              reg_wr_en_d   = 1'b1;
              reg_wr_addr_d = bus.wr_reg;
              reg_wr_data_d = bus.alu_out;
            end
            K_BEQ: begin
              branch_taken_d = bus.zero;
              branch_addr_d  = bus.branch_target;
            end
            K_SW, K_LW: begin
              state_d     = MEM_WAIT;
              cnt_d       = '0;
              mem_req_d   = 1'b1;
              mem_we_d    = (kind == K_SW);
              mem_addr_d  = bus.alu_out;
              mem_wdata_d = bus.store_data;
              wb_addr_d   = bus.wr_reg;
            end
            default: ;
          endcase
        end
      end
      MEM_WAIT: begin
        // an acknowledge on the last counted cycle still completes the access
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          if (mem_we_q) begin
            state_d = IDLE;
          end else begin
            state_d       = WB;
            reg_wr_en_d   = 1'b1;
            reg_wr_addr_d = wb_addr_q;
            reg_wr_data_d = bus.mem_rdata;
          end
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      wb_addr_q      <= '0;
      reg_wr_en_q    <= 1'b0;
      reg_wr_addr_q  <= '0;
      reg_wr_data_q  <= '0;
      branch_taken_q <= 1'b0;
      branch_addr_q  <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wb_addr_q      <= wb_addr_d;
      reg_wr_en_q    <= reg_wr_en_d;
      reg_wr_addr_q  <= reg_wr_addr_d;
      reg_wr_data_q  <= reg_wr_data_d;
      branch_taken_q <= branch_taken_d;
      branch_addr_q  <= branch_addr_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_err_q      <= mem_err_d;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.reg_wr_en    = reg_wr_en_q;
  assign bus.reg_wr_addr  = reg_wr_addr_q;
  assign bus.reg_wr_data  = reg_wr_data_q;
  assign bus.branch_taken = branch_taken_q;
  assign bus.branch_addr  = branch_addr_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_err      = mem_err_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback; strobe events are checked against a
// scoreboard queue, handshake timing is checked inline.
module tb_alu_writeback;

  localparam int unsigned TIMEOUT = 16;
  localparam logic [1:0] EV_REGWR  = 2'd0;
  localparam logic [1:0] EV_BRANCH = 2'd1;
  localparam logic [1:0] EV_MEMERR = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] addr;
    logic [7:0] data;
  } evt_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  evt_t exp_q[$];

  alu_writeback_if bus ();

  alu_writeback #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input logic [1:0] kind, input logic [7:0] addr, input logic [7:0] data);
    evt_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] fn, input logic [7:0] alu,
                       input logic z, input logic [7:0] sd, input logic [2:0] wr,
                       input logic [7:0] bt);
    bus.in_valid      = 1'b1;
    bus.op            = op;
    bus.func          = fn;
    bus.alu_out       = alu;
    bus.zero          = z;
    bus.store_data    = sd;
    bus.wr_reg        = wr;
    bus.branch_target = bt;
    tick();
    bus.in_valid      = 1'b0;
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected event
  task automatic observe(input logic [1:0] kind, input logic [7:0] addr, input logic [7:0] data);
    evt_t got;
    evt_t want;
    got.kind = kind;
    got.addr = addr;
    got.data = data;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind=%0d addr=0x%0h data=0x%0h expected no event",
               kind, addr, data);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL sb_event: got kind=%0d addr=0x%0h data=0x%0h expected kind=%0d addr=0x%0h data=0x%0h",
                 got.kind, got.addr, got.data, want.kind, want.addr, want.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.reg_wr_en === 1'b1)    observe(EV_REGWR, 8'(bus.reg_wr_addr), bus.reg_wr_data);
      if (bus.branch_taken === 1'b1) observe(EV_BRANCH, bus.branch_addr, 8'h00);
      if (bus.mem_err === 1'b1)      observe(EV_MEMERR, 8'h00, 8'h00);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.op = '0; bus.func = '0; bus.alu_out = '0; bus.zero = 1'b0;
    bus.store_data = '0; bus.wr_reg = '0; bus.branch_target = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    // reset with an instruction presented: must not be accepted
    tick();
    bus.in_valid = 1'b1; bus.op = 2'b00; bus.func = 2'b00; bus.alu_out = 8'hEE; bus.wr_reg = 3'd1;
    tick();
    chk("rst_reg_wr_en", 32'(bus.reg_wr_en), 0);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_branch", 32'(bus.branch_taken), 0);
    chk("rst_mem_err", 32'(bus.mem_err), 0);
    chk("rst_reg_wr_data", 32'(bus.reg_wr_data), 0);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);
    chk("post_rst_reg_wr_en", 32'(bus.reg_wr_en), 0);

    // ADD: write at N+1, quiet at N+2
    expect_evt(EV_REGWR, 8'd3, 8'h5A);
    issue(2'b00, 2'b00, 8'h5A, 1'b0, 8'h00, 3'd3, 8'h00);
    chk("add_wr_en", 32'(bus.reg_wr_en), 1);
    tick();
    chk("add_wr_en_drop", 32'(bus.reg_wr_en), 0);

    // back-to-back ALU writes, including register 0, then NOPs
    expect_evt(EV_REGWR, 8'd1, 8'h11);
    expect_evt(EV_REGWR, 8'd0, 8'h22);
    expect_evt(EV_REGWR, 8'd7, 8'h33);
    issue(2'b01, 2'b10, 8'h11, 1'b0, 8'h00, 3'd1, 8'h00);
    issue(2'b10, 2'b01, 8'h22, 1'b0, 8'h00, 3'd0, 8'h00);
    issue(2'b11, 2'b00, 8'h33, 1'b0, 8'h00, 3'd7, 8'h00);
    chk("b2b_in_ready", 32'(bus.in_ready), 1);
    issue(2'b10, 2'b10, 8'h44, 1'b0, 8'h00, 3'd2, 8'h00);
    issue(2'b11, 2'b11, 8'h55, 1'b0, 8'h00, 3'd2, 8'h00);
    chk("nop_mem_req", 32'(bus.mem_req), 0);
    tick();

    // BEQ back-to-back: taken then not taken
    expect_evt(EV_BRANCH, 8'h40, 8'h00);
    issue(2'b00, 2'b01, 8'h00, 1'b1, 8'h00, 3'd4, 8'h40);
    chk("beq1_taken", 32'(bus.branch_taken), 1);
    chk("beq1_addr", 32'(bus.branch_addr), 32'h40);
    issue(2'b00, 2'b11, 8'h00, 1'b0, 8'h00, 3'd4, 8'h66);
    chk("beq2_taken", 32'(bus.branch_taken), 0);
    tick();

    // stray acknowledge while idle is ignored
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hFF;
    tick();
    bus.mem_ack = 1'b0;
    chk("stray_ack_in_ready", 32'(bus.in_ready), 1);
    chk("stray_ack_mem_req", 32'(bus.mem_req), 0);

    // LW with acknowledge in the fourth request cycle
    expect_evt(EV_REGWR, 8'd5, 8'hC3);
    issue(2'b01, 2'b01, 8'h10, 1'b0, 8'h00, 3'd5, 8'h00);
    for (int i = 0; i < 4; i++) begin
      chk("lw_mem_req", 32'(bus.mem_req), 1);
      chk("lw_mem_addr", 32'(bus.mem_addr), 32'h10);
      chk("lw_mem_we", 32'(bus.mem_we), 0);
      chk("lw_in_ready", 32'(bus.in_ready), 0);
      if (i == 3) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'hC3;
      end
      tick();
    end
    bus.mem_ack = 1'b0;
    chk("lw_wb_wr_en", 32'(bus.reg_wr_en), 1);
    chk("lw_wb_in_ready", 32'(bus.in_ready), 0);
    chk("lw_wb_mem_req", 32'(bus.mem_req), 0);
    tick();
    chk("lw_done_in_ready", 32'(bus.in_ready), 1);

    // LW at minimum latency
    expect_evt(EV_REGWR, 8'd7, 8'h9E);
    issue(2'b01, 2'b01, 8'h33, 1'b0, 8'h00, 3'd7, 8'h00);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h9E;
    tick();
    bus.mem_ack = 1'b0;
    chk("lwmin_wr_en", 32'(bus.reg_wr_en), 1);
    chk("lwmin_in_ready_wb", 32'(bus.in_ready), 0);
    tick();
    chk("lwmin_in_ready", 32'(bus.in_ready), 1);

    // SW with no acknowledge: full timeout then error pulse
    expect_evt(EV_MEMERR, 8'h00, 8'h00);
    issue(2'b01, 2'b00, 8'h22, 1'b0, 8'h77, 3'd6, 8'h00);
    n = 0;
    while (bus.mem_req === 1'b1 && n < 40) begin
      chk("sw_mem_addr", 32'(bus.mem_addr), 32'h22);
      chk("sw_mem_we", 32'(bus.mem_we), 1);
      chk("sw_mem_wdata", 32'(bus.mem_wdata), 32'h77);
      chk("sw_mem_err_early", 32'(bus.mem_err), 0);
      n++;
      tick();
    end
    chk("sw_timeout_len", 32'(n), 32'(TIMEOUT));
    chk("sw_timeout_err", 32'(bus.mem_err), 1);
    chk("sw_timeout_in_ready", 32'(bus.in_ready), 1);
    tick();
    chk("sw_err_pulse", 32'(bus.mem_err), 0);

    // SW acknowledged in the second cycle: no write, no error
    issue(2'b01, 2'b00, 8'h44, 1'b0, 8'h88, 3'd1, 8'h00);
    tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("swack_mem_req", 32'(bus.mem_req), 0);
    chk("swack_in_ready", 32'(bus.in_ready), 1);
    chk("swack_reg_wr_en", 32'(bus.reg_wr_en), 0);
    tick();

    // LW acknowledged on the final counted cycle: ack beats timeout
    expect_evt(EV_REGWR, 8'd2, 8'h5B);
    issue(2'b01, 2'b01, 8'h61, 1'b0, 8'h00, 3'd2, 8'h00);
    for (int i = 1; i < int'(TIMEOUT); i++) tick();
    chk("lwlast_mem_req", 32'(bus.mem_req), 1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h5B;
    tick();
    bus.mem_ack = 1'b0;
    chk("lwlast_wr_en", 32'(bus.reg_wr_en), 1);
    chk("lwlast_mem_err", 32'(bus.mem_err), 0);
    tick();
    chk("lwlast_in_ready", 32'(bus.in_ready), 1);

    // reset in the second wait cycle of an LW, late acknowledge ignored
    issue(2'b01, 2'b01, 8'h50, 1'b0, 8'h00, 3'd6, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstwait_mem_req", 32'(bus.mem_req), 0);
    chk("rstwait_reg_wr_en", 32'(bus.reg_wr_en), 0);
    chk("rstwait_mem_err", 32'(bus.mem_err), 0);
    chk("rstwait_in_ready", 32'(bus.in_ready), 1);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hAA;
    tick();
    bus.mem_ack = 1'b0;
    chk("rstwait_late_ack_wr_en", 32'(bus.reg_wr_en), 0);
    chk("rstwait_late_ack_req", 32'(bus.mem_req), 0);
    tick();
    tick();

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
